// File: rtl/delay_filter.sv
// delay_filter: per-channel debounce/qualification filter with separate rise and
// fall thresholds, selectable restart or integrating counting.
module delay_filter #(
   parameter int unsigned         CHANNELS   = 4,
   parameter int unsigned         ON_CYCLES  = 16,
   parameter int unsigned         OFF_CYCLES = 1,
   parameter logic [CHANNELS-1:0] INIT       = '0,
   parameter int unsigned         MODE       = 0
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                en,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                busy
);

   localparam int unsigned MAX_T = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned CW    = $clog2(MAX_T + 1);

   // Count value at which the next mismatching cycle commits the new level.
   localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

   logic [CW-1:0]       cnt_q [CHANNELS];
   logic [CW-1:0]       cnt_d [CHANNELS];
   logic [CHANNELS-1:0] out_d;
   logic [CHANNELS-1:0] rise_d;
   logic [CHANNELS-1:0] fall_d;
   logic                busy_d;

   // Next-state: qualify mismatches per channel, commit on the threshold cycle.
   always_comb begin
      out_d  = out;
      rise_d = '0;
      fall_d = '0;
      busy_d = 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         cnt_d[i] = cnt_q[i];
         if (en) begin
            if (in[i] != out[i]) begin
               // The threshold depends on the direction of the pending transition.
               if (cnt_q[i] >= (out[i] ? OFF_LAST : ON_LAST)) begin
                  out_d[i]  = in[i];
                  cnt_d[i]  = '0;
                  rise_d[i] = in[i];
                  fall_d[i] = ~in[i];
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end else if (MODE == 0) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CW'(1);
            end
         end
         busy_d = busy_d | (cnt_d[i] != '0);
      end
   end

   // State and output registers; async reset discards any partial qualification.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out  <= INIT;
         rise <= '0;
         fall <= '0;
         busy <= 1'b0;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         out  <= out_d;
         rise <= rise_d;
         fall <= fall_d;
         busy <= busy_d;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_delay_filter.sv
// tb_delay_filter: directed tests for delay_filter in restart mode, integrating
// mode, and with a non-zero reset value.
module tb_delay_filter;

   logic       CLK;
   logic       RST_N;
   logic       en;
   logic [3:0] in0, in1, in2;
   logic [3:0] out0, out1, out2;
   logic [3:0] rise0, rise1, rise2;
   logic [3:0] fall0, fall1, fall2;
   logic       busy0, busy1, busy2;

   int nvec;
   int nerr;

   // Restart mode, defaults.
   delay_filter #(.CHANNELS(4), .ON_CYCLES(16), .OFF_CYCLES(1), .INIT(4'b0000), .MODE(0)) u_m0 (
      .CLK(CLK), .RST_N(RST_N), .en(en), .in(in0),
      .out(out0), .rise(rise0), .fall(fall0), .busy(busy0));

   // Integrating mode.
   delay_filter #(.CHANNELS(4), .ON_CYCLES(16), .OFF_CYCLES(1), .INIT(4'b0000), .MODE(1)) u_m1 (
      .CLK(CLK), .RST_N(RST_N), .en(en), .in(in1),
      .out(out1), .rise(rise1), .fall(fall1), .busy(busy1));

   // Non-zero reset value.
   delay_filter #(.CHANNELS(4), .ON_CYCLES(16), .OFF_CYCLES(1), .INIT(4'b1010), .MODE(0)) u_ini (
      .CLK(CLK), .RST_N(RST_N), .en(en), .in(in2),
      .out(out2), .rise(rise2), .fall(fall2), .busy(busy2));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      en    = 1'b1;
      in0   = 4'b0000;
      in1   = 4'b0000;
      in2   = 4'b1010;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      in0 = 4'b0001;
      repeat (3) tick();
      nvec++;
      if (busy0 !== 1'b1) begin nerr++; $display("FAIL reset_pre_busy: got %b want 1", busy0); end
      #2 RST_N = 1'b0;
      #1;
      nvec++;
      if (out0 !== 4'b0000) begin nerr++; $display("FAIL reset_out0: got %b want 0000", out0); end
      nvec++;
      if (busy0 !== 1'b0) begin nerr++; $display("FAIL reset_busy0: got %b want 0", busy0); end
      nvec++;
      if (out2 !== 4'b1010) begin nerr++; $display("FAIL reset_out2: got %b want 1010", out2); end
      nvec++;
      if ({rise0, fall0, rise2, fall2} !== 16'h0) begin
         nerr++; $display("FAIL reset_pulses: got %h want 0000", {rise0, fall0, rise2, fall2});
      end
      repeat (2) tick();
      nvec++;
      if ({out0, busy0} !== 5'b00000) begin nerr++; $display("FAIL reset_held: got %b want 00000", {out0, busy0}); end
      RST_N = 1'b1;
   endtask

   task automatic test_rise();
      logic [3:0] eo, er;
      do_reset();
      in0 = 4'b0001;
      for (int n = 1; n <= 16; n++) begin
         tick();
         eo = (n >= 16) ? 4'b0001 : 4'b0000;
         er = (n == 16) ? 4'b0001 : 4'b0000;
         nvec++;
         if (out0 !== eo) begin nerr++; $display("FAIL rise_out edge %0d: got %b want %b", n, out0, eo); end
         nvec++;
         if (rise0 !== er) begin nerr++; $display("FAIL rise_pulse edge %0d: got %b want %b", n, rise0, er); end
         nvec++;
         if (busy0 !== (n < 16)) begin nerr++; $display("FAIL rise_busy edge %0d: got %b want %b", n, busy0, (n < 16)); end
      end
      tick();
      nvec++;
      if ({out0, rise0, fall0} !== 12'b0001_0000_0000) begin
         nerr++; $display("FAIL rise_after: got %b want 000100000000", {out0, rise0, fall0});
      end
   endtask

   task automatic test_fall();
      do_reset();
      in0 = 4'b0001;
      repeat (16) tick();
      in0 = 4'b0000;
      tick();
      nvec++;
      if (out0 !== 4'b0000) begin nerr++; $display("FAIL fall_out: got %b want 0000", out0); end
      nvec++;
      if (fall0 !== 4'b0001) begin nerr++; $display("FAIL fall_pulse: got %b want 0001", fall0); end
      nvec++;
      if (rise0 !== 4'b0000) begin nerr++; $display("FAIL fall_no_rise: got %b want 0000", rise0); end
      tick();
      nvec++;
      if ({fall0, busy0} !== 5'b00000) begin nerr++; $display("FAIL fall_after: got %b want 00000", {fall0, busy0}); end
   endtask

   task automatic test_multi();
      do_reset();
      in0 = 4'b0110;
      repeat (15) tick();
      nvec++;
      if (out0 !== 4'b0000) begin nerr++; $display("FAIL multi_early: got %b want 0000", out0); end
      tick();
      nvec++;
      if (out0 !== 4'b0110) begin nerr++; $display("FAIL multi_out: got %b want 0110", out0); end
      nvec++;
      if (rise0 !== 4'b0110) begin nerr++; $display("FAIL multi_rise: got %b want 0110", rise0); end
      in0 = 4'b0101;
      tick();
      nvec++;
      if ({out0, rise0, fall0, busy0} !== 13'b0100_0000_0010_1) begin
         nerr++; $display("FAIL multi_mixed: got %b want 0100000000101", {out0, rise0, fall0, busy0});
      end
   endtask

   task automatic test_restart();
      logic [3:0] eo, er;
      do_reset();
      for (int n = 1; n <= 29; n++) begin
         in0 = (n == 11) ? 4'b0000 : 4'b0001;
         tick();
         eo = (n >= 27) ? 4'b0001 : 4'b0000;
         er = (n == 27) ? 4'b0001 : 4'b0000;
         nvec++;
         if (out0 !== eo) begin nerr++; $display("FAIL restart_out edge %0d: got %b want %b", n, out0, eo); end
         nvec++;
         if (rise0 !== er) begin nerr++; $display("FAIL restart_rise edge %0d: got %b want %b", n, rise0, er); end
      end
   endtask

   task automatic test_integrate();
      logic [3:0] eo, er;
      do_reset();
      for (int n = 1; n <= 20; n++) begin
         in1 = (n == 11) ? 4'b0000 : 4'b0001;
         tick();
         eo = (n >= 18) ? 4'b0001 : 4'b0000;
         er = (n == 18) ? 4'b0001 : 4'b0000;
         nvec++;
         if (out1 !== eo) begin nerr++; $display("FAIL integ_out edge %0d: got %b want %b", n, out1, eo); end
         nvec++;
         if (rise1 !== er) begin nerr++; $display("FAIL integ_rise edge %0d: got %b want %b", n, rise1, er); end
      end
      nvec++;
      if (busy1 !== 1'b0) begin nerr++; $display("FAIL integ_busy: got %b want 0", busy1); end
   endtask

   task automatic test_enable();
      logic [3:0] eo, er;
      do_reset();
      in0 = 4'b0001;
      for (int n = 1; n <= 22; n++) begin
         en = !(n >= 6 && n <= 10);
         tick();
         eo = (n >= 21) ? 4'b0001 : 4'b0000;
         er = (n == 21) ? 4'b0001 : 4'b0000;
         nvec++;
         if (out0 !== eo) begin nerr++; $display("FAIL enable_out edge %0d: got %b want %b", n, out0, eo); end
         nvec++;
         if ({rise0, fall0} !== {er, 4'b0000}) begin
            nerr++; $display("FAIL enable_pulse edge %0d: got %b want %b", n, {rise0, fall0}, {er, 4'b0000});
         end
      end
      en = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [3:0] eo, er;
      do_reset();
      in2 = 4'b0010;
      tick();
      nvec++;
      if ({out2, fall2} !== 8'b0010_1000) begin nerr++; $display("FAIL mid_drop: got %b want 00101000", {out2, fall2}); end
      in2 = 4'b0011;
      repeat (12) tick();
      nvec++;
      if ({out2, busy2} !== 5'b0010_1) begin nerr++; $display("FAIL mid_pre: got %b want 00101", {out2, busy2}); end
      #2 RST_N = 1'b0;
      #1;
      nvec++;
      if (out2 !== 4'b1010) begin nerr++; $display("FAIL mid_out: got %b want 1010", out2); end
      nvec++;
      if ({busy2, rise2, fall2} !== 9'b0) begin nerr++; $display("FAIL mid_clear: got %b want 000000000", {busy2, rise2, fall2}); end
      #2 RST_N = 1'b1;
      in2 = 4'b1011;
      for (int n = 1; n <= 16; n++) begin
         tick();
         eo = (n == 16) ? 4'b1011 : 4'b1010;
         er = (n == 16) ? 4'b0001 : 4'b0000;
         nvec++;
         if (out2 !== eo) begin nerr++; $display("FAIL mid_out edge %0d: got %b want %b", n, out2, eo); end
         nvec++;
         if (rise2 !== er) begin nerr++; $display("FAIL mid_rise edge %0d: got %b want %b", n, rise2, er); end
      end
   endtask

   initial begin
      nvec  = 0;
      nerr  = 0;
      RST_N = 1'b0;
      en    = 1'b1;
      in0   = 4'b0000;
      in1   = 4'b0000;
      in2   = 4'b1010;
      test_reset();
      test_rise();
      test_fall();
      test_multi();
      test_restart();
      test_integrate();
      test_enable();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
